// File: rtl/multi_enabler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_enabler_pkg
// Description : Shared mode encodings and helpers for the multi-channel
//               hold-enable counter.
// Revision    : 1.0 - initial release
// ============================================================================
package multi_enabler_pkg;

   // Mode field width per channel
   localparam int MODE_W = 2;

   // Channel mode encodings
   localparam logic [MODE_W-1:0] MODE_ONESHOT = 2'b00;
   localparam logic [MODE_W-1:0] MODE_RELOAD  = 2'b01;
   localparam logic [MODE_W-1:0] MODE_FREERUN = 2'b10;
   localparam logic [MODE_W-1:0] MODE_RSVD    = 2'b11;

   // Free-run counts every clock; every other mode (reserved included)
   // advances only on enable.
   function automatic logic mode_step(input logic [MODE_W-1:0] mode,
                                      input logic              enable);
      return (mode == MODE_FREERUN) ? 1'b1 : enable;
   endfunction

   // Gate output: free-run ignores enable, the rest qualify with it.
   function automatic logic mode_gate(input logic [MODE_W-1:0] mode,
                                      input logic              enable,
                                      input logic              nonzero);
      return (mode == MODE_FREERUN) ? nonzero : (enable & nonzero);
   endfunction

   // Only the reload mode wraps back to the stored value on expiry.
   function automatic logic mode_wraps(input logic [MODE_W-1:0] mode);
      return (mode == MODE_RELOAD);
   endfunction

endpackage : multi_enabler_pkg
`default_nettype wire

// File: rtl/multi_enabler_channel.sv
`default_nettype none
// ============================================================================
// Module      : enabler_channel
// Description : One hold-enable channel: down-counter with stored reload
//               value, registered done pulse and combinational gate output.
// Revision    : 1.0 - initial release
// ============================================================================
module enabler_channel
   import multi_enabler_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_i,
   input  logic [WIDTH-1:0]  load_count_i,
   input  logic [MODE_W-1:0] mode_i,
   input  logic              enable_i,
   input  logic              abort_i,
   output logic              enabled_o,
   output logic              done_o,
   output logic              active_o
);

   localparam logic [WIDTH-1:0] C_ZERO = '0;
   localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             done_q, done_d;

   logic             nonzero_w;
   logic             step_w;
   logic             last_w;

   assign nonzero_w = (count_q != C_ZERO);
   assign step_w    = mode_step(mode_i, enable_i);
   assign last_w    = (count_q == C_ONE);

   // Next-state: abort beats load beats decrement; done marks the taken
   // decrement from 1 (expiry in one-shot/free-run, wrap in reload).
   always_comb begin
      count_d  = count_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      if (abort_i) begin
         count_d = C_ZERO;
      end else if (load_i) begin
         count_d  = load_count_i;
         reload_d = load_count_i;
      end else if (step_w && nonzero_w) begin
         done_d = last_w;
         if (last_w && mode_wraps(mode_i)) begin
            count_d = reload_q;
         end else begin
            count_d = count_q - C_ONE;
         end
      end
   end

   // Channel state registers, cleared asynchronously
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q  <= C_ZERO;
         reload_q <= C_ZERO;
         done_q   <= 1'b0;
      end else begin
         count_q  <= count_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

   assign enabled_o = mode_gate(mode_i, enable_i, nonzero_w);
   assign done_o    = done_q;
   assign active_o  = nonzero_w;

endmodule : enabler_channel
`default_nettype wire

// File: rtl/multi_enabler.sv
`default_nettype none
// ============================================================================
// Module      : multi_enabler
// Description : CHANNELS independent hold-enable counters with per-channel
//               mode, abort and done pulse, plus an aggregate busy flag.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_enabler
   import multi_enabler_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [CHANNELS-1:0]       load,
   input  logic [CHANNELS*WIDTH-1:0] load_count,
   input  logic [CHANNELS*MODE_W-1:0] mode,
   input  logic [CHANNELS-1:0]       enable,
   input  logic [CHANNELS-1:0]       abort,
   output logic [CHANNELS-1:0]       enabled,
   output logic [CHANNELS-1:0]       done,
   output logic                      busy
);

   logic [CHANNELS-1:0] active_w;

   // One channel per slice of the packed input vectors
   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
         enabler_channel #(
            .WIDTH (WIDTH)
         ) u_chan (
            .clk          (clk),
            .reset_n      (reset_n),
            .load_i       (load[gi]),
            .load_count_i (load_count[gi*WIDTH +: WIDTH]),
            .mode_i       (mode[gi*MODE_W +: MODE_W]),
            .enable_i     (enable[gi]),
            .abort_i      (abort[gi]),
            .enabled_o    (enabled[gi]),
            .done_o       (done[gi]),
            .active_o     (active_w[gi])
         );
      end
   endgenerate

   assign busy = |active_w;

endmodule : multi_enabler
`default_nettype wire
